// File: rtl/limb_adder_seq.sv
// limb_adder_seq
//
// Limb-serial sequencer for a narrow external ripple adder. One WIDTH-bit
// add or subtract is built from NLIMB passes through a single LIMB-bit
// combinational adder, least significant limb first. The carry is
// registered between passes, and the full result is returned with a
// start/done handshake.
//
// Parameters:
//   WIDTH  full operand/result width (must be a multiple of LIMB)
//   LIMB   external adder width
//   NLIMB  derived limb count (localparam, not overridable)
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request, sampled only in IDLE
//   sub       0 = a+b, 1 = a-b, sampled with start
//   a, b      operands, sampled with start
//   busy      high in RUN and DONE
//   done      one-cycle pulse, result valid
//   sum       result register (partially updated during RUN)
//   cout      final carry (sub: 1 = no borrow, a >= b)
//   zero      result-is-zero flag (only with LIMB_ADDER_SEQ_ZFLAG_EN)
//   add_a     limb operand A to the external adder
//   add_b     limb operand B to the external adder
//   add_cin   carry-in to the external adder
//   add_sum   limb sum from the external adder
//   add_cout  carry-out from the external adder
//
// Optional feature: define LIMB_ADDER_SEQ_ZFLAG_EN to add the zero output,
// accumulated limb by limb so that no WIDTH-wide reduction is needed.

module limb_adder_seq #(
    parameter int WIDTH = 32,
    parameter int LIMB  = 8,
    localparam int NLIMB = WIDTH / LIMB
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
    output logic             zero,
`endif
    output logic [LIMB-1:0]  add_a,
    output logic [LIMB-1:0]  add_b,
    output logic             add_cin,
    input  logic [LIMB-1:0]  add_sum,
    input  logic             add_cout
);

    localparam int IDXW = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              last_limb;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
    logic              zacc;
`endif

    assign last_limb = (state == RUN) && (idx == IDXW'(NLIMB - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start outside IDLE is dropped, never queued
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_limb) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; the adder inputs are parked at zero outside RUN so the
    // shared adder sees no toggling while idle
    always_comb begin
        busy    = (state == RUN) || (state == DONE);
        done    = (state == DONE);
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < NLIMB; i++) begin
                if (idx == IDXW'(i)) begin
                    add_a = a_reg[i*LIMB +: LIMB];
                    add_b = b_reg[i*LIMB +: LIMB];
                end
            end
            add_cin = carry;
        end
    end

    // Datapath. Subtraction stores ~b and seeds the carry with 1, so the
    // adder computes a + ~b + 1 without any extra hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
            zacc  <= 1'b0;
            zero  <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                if (start) begin
                    a_reg <= a;
                    b_reg <= sub ? ~b : b;
                    carry <= sub;
                    idx   <= '0;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
                    zacc  <= 1'b0;
`endif
                end
            end else if (state == RUN) begin
                for (int i = 0; i < NLIMB; i++) begin
                    if (idx == IDXW'(i)) begin
                        sum[i*LIMB +: LIMB] <= add_sum;
                    end
                end
                carry <= add_cout;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
                zacc  <= zacc | (|add_sum);
`endif
                if (last_limb) begin
                    idx  <= '0;
                    cout <= add_cout;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
                    zero <= ~(zacc | (|add_sum));
`endif
                end else begin
                    idx <= idx + IDXW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_limb_adder_seq.sv
// tb_limb_adder_seq
//
// Directed self-checking bench for limb_adder_seq with default parameters
// (WIDTH=32, LIMB=8). The external limb adder is modelled combinationally
// here; expected results are hand-computed constants.

module tb_limb_adder_seq;

    localparam int WIDTH = 32;
    localparam int LIMB  = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
    logic             zero;
`endif
    logic [LIMB-1:0]  add_a;
    logic [LIMB-1:0]  add_b;
    logic             add_cin;
    logic [LIMB-1:0]  add_sum;
    logic             add_cout;

    int checks;
    int passes;

    limb_adder_seq #(.WIDTH(WIDTH), .LIMB(LIMB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
        .zero     (zero),
`endif
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External ripple adder model
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{LIMB{1'b0}}, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request at a falling edge, let edge E0 take it, then drop start
    task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                 input logic vsub);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        sub   = vsub;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Latency counted in falling edges after E0: 0 is the cycle following E0
    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok  = 1'b1;
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checks++;
        if ({busy, done, cout, add_cin} !== 4'b0000)
            $display("[TB] FAIL reset_flags: busy/done/cout/cin=%b required 0000",
                     {busy, done, cout, add_cin});
        else passes++;
        checks++;
        if (sum !== 32'h0)
            $display("[TB] FAIL reset_sum: got %h required 00000000", sum);
        else passes++;
        checks++;
        if ({add_a, add_b} !== 16'h0)
            $display("[TB] FAIL reset_adder_ports: got %h required 0000", {add_a, add_b});
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0)
            $display("[TB] FAIL idle_busy: got %b required 0", busy);
        else passes++;
    endtask

    task automatic test_add_basic;
        logic exp_done;
        logic exp_busy;
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            exp_done = (k == 4);
            exp_busy = (k <= 4);
            checks++;
            if (done !== exp_done)
                $display("[TB] FAIL add_done_cycle%0d: got %b required %b", k, done, exp_done);
            else passes++;
            checks++;
            if (busy !== exp_busy)
                $display("[TB] FAIL add_busy_cycle%0d: got %b required %b", k, busy, exp_busy);
            else passes++;
            if (k == 0) begin
                checks++;
                if ({add_a, add_b, add_cin} !== {8'hFF, 8'h01, 1'b0})
                    $display("[TB] FAIL add_run_ports: a=%h b=%h cin=%b required a=ff b=01 cin=0",
                             add_a, add_b, add_cin);
                else passes++;
            end
            if (k == 4) begin
                checks++;
                if (sum !== 32'h0000_0100)
                    $display("[TB] FAIL add_sum: got %h required 00000100", sum);
                else passes++;
                checks++;
                if (cout !== 1'b0)
                    $display("[TB] FAIL add_cout: got %b required 0", cout);
                else passes++;
                checks++;
                if ({add_a, add_b, add_cin} !== 17'h0)
                    $display("[TB] FAIL done_ports: a=%h b=%h cin=%b required 0",
                             add_a, add_b, add_cin);
                else passes++;
            end
        end
    endtask

    task automatic test_add_ripple;
        int lat;
        bit ok;
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 4)
            $display("[TB] FAIL ripple_latency: got ok=%0d lat=%0d required ok=1 lat=4", ok, lat);
        else passes++;
        checks++;
        if ({cout, sum} !== {1'b1, 32'h0000_0000})
            $display("[TB] FAIL ripple_result: got cout=%b sum=%h required 1 00000000", cout, sum);
        else passes++;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
        checks++;
        if (zero !== 1'b1)
            $display("[TB] FAIL ripple_zero: got %b required 1", zero);
        else passes++;
`endif
    endtask

    task automatic test_sub;
        int lat;
        bit ok;
        applyStimulus(32'd7, 32'd5, 1'b1);
        @(negedge clk);
        checks++;
        if ({add_a, add_b, add_cin} !== {8'h07, 8'hFA, 1'b1})
            $display("[TB] FAIL sub_run_ports: a=%h b=%h cin=%b required a=07 b=fa cin=1",
                     add_a, add_b, add_cin);
        else passes++;
        wait_done(lat, ok);
        checks++;
        if (!ok || {cout, sum} !== {1'b1, 32'h0000_0002})
            $display("[TB] FAIL sub_7_5: got ok=%0d cout=%b sum=%h required 1 00000002",
                     ok, cout, sum);
        else passes++;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
        checks++;
        if (zero !== 1'b0)
            $display("[TB] FAIL sub_7_5_zero: got %b required 0", zero);
        else passes++;
`endif
        applyStimulus(32'd5, 32'd7, 1'b1);
        wait_done(lat, ok);
        checks++;
        if (!ok || {cout, sum} !== {1'b0, 32'hFFFF_FFFE})
            $display("[TB] FAIL sub_5_7: got ok=%0d cout=%b sum=%h required 0 fffffffe",
                     ok, cout, sum);
        else passes++;
`ifdef LIMB_ADDER_SEQ_ZFLAG_EN
        checks++;
        if (zero !== 1'b0)
            $display("[TB] FAIL sub_5_7_zero: got %b required 0", zero);
        else passes++;
`endif
    endtask

    task automatic test_back_to_back;
        int dones;
        int lat;
        bit ok;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 32'h0000_0001;
        b     = 32'h0000_0002;
        sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // start stays high through RUN and DONE with new operands on the bus
        a = 32'hAAAA_AAAA;
        b = 32'h1111_1111;
        if (done === 1'b1) dones++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (done !== 1'b1 || sum !== 32'h0000_0003)
            $display("[TB] FAIL b2b_first: got done=%b sum=%h required 1 00000003", done, sum);
        else passes++;
        checks++;
        if (dones != 1)
            $display("[TB] FAIL b2b_single_done: got %0d pulses required 1", dones);
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00)
            $display("[TB] FAIL b2b_start_in_done_ignored: busy/done=%b required 00",
                     {busy, done});
        else passes++;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, ok);
        checks++;
        if (!ok || lat != 4 || sum !== 32'hBBBB_BBBB)
            $display("[TB] FAIL b2b_second: got ok=%0d lat=%0d sum=%h required 1 4 bbbbbbbb",
                     ok, lat, sum);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit ok;
        bit saw_done;
        applyStimulus(32'd7, 32'd5, 1'b1);
        wait_done(lat, ok);
        checks++;
        if (!ok || cout !== 1'b1)
            $display("[TB] FAIL rstmid_setup: got ok=%0d cout=%b required 1 1", ok, cout);
        else passes++;
        applyStimulus(32'h1234_5678, 32'h0000_0001, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, add_a} !== {1'b1, 8'h34})
            $display("[TB] FAIL rstmid_idx2: busy=%b add_a=%h required 1 34", busy, add_a);
        else passes++;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout} !== 3'b000 || sum !== 32'h0)
            $display("[TB] FAIL rstmid_clear: busy/done/cout=%b sum=%h required 000 00000000",
                     {busy, done, cout}, sum);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done)
            $display("[TB] FAIL rstmid_no_done: got done pulse required none");
        else passes++;
        applyStimulus(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done(lat, ok);
        checks++;
        if (!ok || {cout, sum} !== {1'b0, 32'h0000_0030})
            $display("[TB] FAIL rstmid_recover: got ok=%0d cout=%b sum=%h required 1 0 00000030",
                     ok, cout, sum);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_add_basic();
        test_add_ripple();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/limb_adder_seq.md
Name: limb_adder_seq

Overview:
Limb-serial sequencer for the ALU's narrow ripple adder in the RSA decryption ASIP. It builds one WIDTH-bit add or subtract from NLIMB passes through a single external LIMB-bit adder instance, least significant limb first. It registers the carry between passes and returns the full result with a start/done handshake. Used by the EX stage for multiprecision operand add/sub without widening the adder.

Parameters:
WIDTH, 32, full operand/result width in bits
LIMB, 8, adder width in bits; WIDTH must be an integer multiple of LIMB
NLIMB, WIDTH/LIMB, derived limb count; not to be overridden

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
sub  in  1  0 = a+b, 1 = a-b; sampled with start
a  in  WIDTH  operand A; sampled with start
b  in  WIDTH  operand B; sampled with start
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result valid
sum  out  WIDTH  result register
cout  out  1  final carry (sub: 1 = no borrow, a>=b)
add_a  out  LIMB  to adder a
add_b  out  LIMB  to adder b
add_cin  out  1  to adder cin
add_sum  in  LIMB  from adder sum
add_cout  in  1  from adder cout

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, cout=0, busy=0, done=0. Reset mid-operation aborts it; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE + start=1 at an edge: a_reg<=a; b_reg<=sub ? ~b : b; carry<=sub; idx<=0; go to RUN. start=0 stays in IDLE.
- RUN: add_a=a_reg[idx*LIMB +: LIMB], add_b=b_reg[idx*LIMB +: LIMB], add_cin=carry; the adder is purely combinational.
- RUN, each edge: sum[idx*LIMB +: LIMB]<=add_sum; carry<=add_cout; idx<=idx+1.
- When idx==NLIMB-1 at that edge: cout<=add_cout, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outside RUN: add_a=0, add_b=0, add_cin=0.
- Latency: start sampled at edge E0; done is high in the cycle after edge E_NLIMB (4 cycles for the defaults). Throughput is one op per NLIMB+2 cycles.
- start in RUN or DONE (including the done cycle) is ignored and not queued.
- a, b and sub may change freely after the start edge; the result uses the sampled values.
- sum is partially updated during RUN and is valid only from the done cycle until the next accepted start. cout holds its value until the next operation completes.
- Arithmetic is modulo 2^WIDTH. Subtract is two's complement (~b + 1 via cin).
- NLIMB=1 is legal: one RUN cycle.

Optional Feature:
Macro LIMB_ADDER_SEQ_ZFLAG_EN.
- Defined: adds output port zero (1 bit, reset 0). It is built incrementally: zacc is cleared on accepted start and ORs in |add_sum each RUN cycle. zero<=~(zacc | |add_sum) on the final limb and holds until the next completion.
- Undefined: no zero port and no zacc logic; all other behaviour is identical.

Test Plan:
- add a=0x000000FF, b=0x00000001, start at E0 -> done high after E4 only, sum=0x00000100, cout=0, busy high E1..E4 cycles.
- add a=0xFFFFFFFF, b=0x00000001 -> carry ripples all 4 limbs; sum=0x00000000, cout=1 (zero=1 if ZFLAG_EN).
- sub a=7, b=5 -> sum=0x00000002, cout=1; sub a=5, b=7 -> sum=0xFFFFFFFE, cout=0 (zero=0).
- Accept add a=1, b=2, then hold start=1 and change a=0xAAAAAAAA during RUN -> result sum=3, single done pulse; start during the done cycle is ignored; start the following cycle is accepted.
- Assert rst asynchronously while idx=2 -> busy, done, sum, cout go 0 immediately; no done afterwards; next start a=0x10, b=0x20 gives sum=0x30.
- Check adder port drive: add_a/add_b/add_cin=0 in IDLE and DONE; in RUN with sub=1 the first limb shows add_cin=1 and add_b=~b[7:0].
